frame_ram_arbiter: RTL and testbench
====================================

FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, giving the external frame RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the external frame RAM data width.
REQ-003 The block SHALL have parameter LEN_W, default 4, giving the burst-length field width; the field encodes beats-1, so the maximum burst is 16 beats.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset: `clk` is an input, 1 bit, the sole clock (rising edge).
REQ-005 `reset` is an input, 1 bit, the asynchronous active-high reset.
REQ-006 `dis_req`, `rec_req` and `mc_req` are inputs, 1 bit each, requesting display read, reconstruction write and motion-compensation read respectively.
REQ-007 `dis_addr`, `rec_addr` and `mc_addr` are inputs, ADDR_W bits each, giving each requester's burst base address.
REQ-008 `dis_len`, `rec_len` and `mc_len` are inputs, LEN_W bits each, giving each requester's beats-1.
REQ-009 `rec_wdata` is an input, DATA_W bits, carrying write data for the current beat.
REQ-010 `dis_gnt`, `rec_gnt` and `mc_gnt` are outputs, 1 bit each, pulsing in the first beat cycle of the granted burst.
REQ-011 `rec_wready` is an output, 1 bit, high in each write-beat cycle; `rec_wdata` is consumed in that cycle.
REQ-012 `dis_rvalid` and `mc_rvalid` are outputs, 1 bit each, marking `rdata` valid for the owning reader.
REQ-013 `rdata` is an output, DATA_W bits, carrying shared read-return data.
REQ-014 `ram_cs_n`, `ram_wr`, `ram_addr` and `ram_wdata` are outputs of 1, 1, ADDR_W and DATA_W bits, driving the external frame RAM.
REQ-015 `ram_rdata` is an input, DATA_W bits, carrying RAM read data, valid one cycle after a read beat.
REQ-016 `busy` is an output, 1 bit, high whenever the block is not in the IDLE state.

Function
REQ-017 The state machine SHALL have two states, IDLE and BURST.
- IDLE: `ram_cs_n`=1, `ram_wr`=0.
- BURST: one beat per cycle, `ram_cs_n`=0.
REQ-018 When the block is in IDLE and any request is high at a clock edge, it SHALL latch the winner's address and length, enter BURST, and pulse that winner's gnt for exactly one cycle, coincident with beat 0.
REQ-019 Priority SHALL be: `dis_req` first, always; `rec_req` and `mc_req` are resolved by a round-robin pointer.
- The pointer flips to the other requester after each completed rec or mc burst.
- The pointer is unchanged by display bursts.
REQ-020 Beat k SHALL drive `ram_addr` = base + k modulo 2^ADDR_W, so address 2^ADDR_W-1 wraps to 0.
REQ-021 The burst SHALL issue exactly len+1 beats, then return to IDLE for at least one cycle; consecutive bursts are therefore separated by one or more cycles with `ram_cs_n`=1.
REQ-022 For a rec burst, each beat SHALL drive `ram_wr`=1, `ram_wdata`=`rec_wdata` and `rec_wready`=1.
REQ-023 For a read burst, the owner's rvalid SHALL be high in the cycle after each beat, with `rdata`=`ram_rdata` in that cycle.
- The final rvalid falls in the IDLE cycle that follows the burst.
- The non-owning reader's rvalid stays 0.
REQ-024 Requests and addr/len values changing during a burst SHALL be ignored; the latched burst always completes.
REQ-025 A request still high when the block returns to IDLE SHALL be treated as a new request.
REQ-026 `rec_wready` SHALL be 0 in every cycle that is not a write beat.
REQ-027 All gnt and rvalid outputs SHALL be mutually exclusive.
REQ-028 `ram_wdata` SHALL be 0 in any cycle where `ram_wr`=0.

Reset
REQ-029 While `reset` is high, the block SHALL immediately, without waiting for a clock edge, force:
- state = IDLE;
- `ram_cs_n`=1;
- `ram_wr`=0, `ram_addr`=0, `ram_wdata`=0;
- all gnt, rvalid and `rec_wready` outputs = 0;
- `rdata`=0, `busy`=0;
- round-robin pointer = rec.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no further beats and no pending rvalid; the first edge after reset deassertion evaluates requests from IDLE.

Structure
REQ-031 Shared package `frame_ram_pkg` SHALL hold ADDR_W, DATA_W, LEN_W, the state enumeration {IDLE, BURST} and the requester-ID enumeration {DIS, REC, MC}.
REQ-032 The winner selection (fixed priority plus round-robin) SHALL be a separate combinational sub-module `frame_ram_arb_pick`; counters, latches and the FSM stay in the top module.

Verification
REQ-033 Write: `rec_req`, `rec_addr`=0x0010, `rec_len`=3 -> `rec_gnt` pulses once; four cycles of `ram_cs_n`=0, `ram_wr`=1 with `ram_addr` 0x0010..0x0013 and `rec_wready`=1; then `ram_cs_n`=1.
REQ-034 Wrap: `mc_req`, `mc_addr`=0x3FFE, `mc_len`=3 -> `ram_addr` 0x3FFE, 0x3FFF, 0x0000, 0x0001; `mc_rvalid` high for 4 cycles, each one cycle after its beat, with `rdata` equal to the driven `ram_rdata`.
REQ-035 Priority: dis, rec and mc requests raised in the same cycle and held -> service order dis, rec, mc, with exactly one IDLE cycle between bursts.
REQ-036 Fairness: rec and mc held high continuously, each with len=0 -> grants alternate rec, mc, rec, mc.
REQ-037 Reset: reset asserted during beat 2 of a rec len=7 burst -> `ram_cs_n`=1 and `ram_wr`=0 within the same cycle, `busy`=0, and no beats 3..7 issued after release.
REQ-038 Mid-burst change: `dis_addr` changed and `dis_req` dropped during a 16-beat display burst -> all 16 beats issued at the original addresses.

Source files
------------

// File: rtl/frame_ram_pkg.sv
// Shared widths and enumerations for the frame RAM arbiter.
package frame_ram_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;

  typedef enum logic {IDLE, BURST} state_e;

  typedef enum logic [1:0] {DIS, REC, MC} req_id_e;

endpackage

// File: rtl/frame_ram_arb_pick.sv
// Winner selection: display has absolute priority, rec/mc share a round-robin pointer.
module frame_ram_arb_pick
  import frame_ram_pkg::*;
(
  input  logic    dis_req,
  input  logic    rec_req,
  input  logic    mc_req,
  input  logic    rr_mc,
  output logic    any_req,
  output req_id_e winner
);

  assign any_req = dis_req | rec_req | mc_req;

  always_comb begin
    winner = DIS;
    if (dis_req) begin
      winner = DIS;
    end else if (rec_req && mc_req) begin
      winner = rr_mc ? MC : REC;
    end else if (rec_req) begin
      winner = REC;
    end else if (mc_req) begin
      winner = MC;
    end
  end

endmodule

// File: rtl/frame_ram_arbiter.sv
// Three-way burst arbiter for an external single-port frame RAM
// (display read, reconstruction write, motion-compensation read).
module frame_ram_arbiter #(
  parameter int unsigned ADDR_W = frame_ram_pkg::ADDR_W,
  parameter int unsigned DATA_W = frame_ram_pkg::DATA_W,
  parameter int unsigned LEN_W  = frame_ram_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dis_req,
  input  logic              rec_req,
  input  logic              mc_req,
  input  logic [ADDR_W-1:0] dis_addr,
  input  logic [ADDR_W-1:0] rec_addr,
  input  logic [ADDR_W-1:0] mc_addr,
  input  logic [LEN_W-1:0]  dis_len,
  input  logic [LEN_W-1:0]  rec_len,
  input  logic [LEN_W-1:0]  mc_len,
  input  logic [DATA_W-1:0] rec_wdata,
  output logic              dis_gnt,
  output logic              rec_gnt,
  output logic              mc_gnt,
  output logic              rec_wready,
  output logic              dis_rvalid,
  output logic              mc_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_cs_n,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  import frame_ram_pkg::*;

  state_e            state_q;
  req_id_e           owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              rr_mc_q;
  logic [2:0]        gnt_q;
  logic              dis_rvalid_q;
  logic              mc_rvalid_q;

  logic              any_req;
  req_id_e           winner;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;

  frame_ram_arb_pick u_pick (
    .dis_req (dis_req),
    .rec_req (rec_req),
    .mc_req  (mc_req),
    .rr_mc   (rr_mc_q),
    .any_req (any_req),
    .winner  (winner)
  );

  always_comb begin
    base = dis_addr;
    len  = dis_len;
    unique case (winner)
      DIS: begin
        base = dis_addr;
        len  = dis_len;
      end
      REC: begin
        base = rec_addr;
        len  = rec_len;
      end
      MC: begin
        base = mc_addr;
        len  = mc_len;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= DIS;
      addr_q       <= '0;
      cnt_q        <= '0;
      rr_mc_q      <= 1'b0;
      gnt_q        <= '0;
      dis_rvalid_q <= 1'b0;
      mc_rvalid_q  <= 1'b0;
    end else begin
      gnt_q        <= '0;
      // Read data returns one cycle after each beat, so rvalid trails the beat by one.
      dis_rvalid_q <= (state_q == BURST) && (owner_q == DIS);
      mc_rvalid_q  <= (state_q == BURST) && (owner_q == MC);
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= BURST;
            owner_q <= winner;
            addr_q  <= base;
            cnt_q   <= len;
            gnt_q   <= {winner == DIS, winner == REC, winner == MC};
          end
        end
        BURST: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            // Pointer favours the other side after rec/mc; display leaves it alone.
            if (owner_q != DIS) begin
              rr_mc_q <= (owner_q == REC);
            end
          end else begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign busy       = (state_q == BURST);
  assign ram_cs_n   = ~busy;
  assign ram_wr     = busy && (owner_q == REC);
  assign rec_wready = ram_wr;
  assign ram_addr   = busy ? addr_q : '0;
  assign ram_wdata  = ram_wr ? rec_wdata : '0;

  assign dis_gnt    = gnt_q[2];
  assign rec_gnt    = gnt_q[1];
  assign mc_gnt     = gnt_q[0];
  assign dis_rvalid = dis_rvalid_q;
  assign mc_rvalid  = mc_rvalid_q;
  assign rdata      = (dis_rvalid_q || mc_rvalid_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter: inputs change on the falling edge, outputs sampled there.
module tb_frame_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        dis_req, rec_req, mc_req;
  logic [13:0] dis_addr, rec_addr, mc_addr;
  logic [3:0]  dis_len, rec_len, mc_len;
  logic [31:0] rec_wdata;
  logic        dis_gnt, rec_gnt, mc_gnt;
  logic        rec_wready, dis_rvalid, mc_rvalid;
  logic [31:0] rdata;
  logic        ram_cs_n, ram_wr;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_ram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .dis_req    (dis_req),
    .rec_req    (rec_req),
    .mc_req     (mc_req),
    .dis_addr   (dis_addr),
    .rec_addr   (rec_addr),
    .mc_addr    (mc_addr),
    .dis_len    (dis_len),
    .rec_len    (rec_len),
    .mc_len     (mc_len),
    .rec_wdata  (rec_wdata),
    .dis_gnt    (dis_gnt),
    .rec_gnt    (rec_gnt),
    .mc_gnt     (mc_gnt),
    .rec_wready (rec_wready),
    .dis_rvalid (dis_rvalid),
    .mc_rvalid  (mc_rvalid),
    .rdata      (rdata),
    .ram_cs_n   (ram_cs_n),
    .ram_wr     (ram_wr),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [13:0] ea;
    logic [2:0]  eg;
    logic [2:0]  prio_seq [6];
    logic [2:0]  fair_seq [8];
    int          stray;

    prio_seq = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000};
    fair_seq = '{3'b010, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000};

    reset = 1'b1;
    {dis_req, rec_req, mc_req} = '0;
    dis_addr = '0; rec_addr = '0; mc_addr = '0;
    dis_len = '0; rec_len = '0; mc_len = '0;
    rec_wdata = '0; ram_rdata = '0;

    // Reset state
    @(negedge clk);
    check("rst_cs_n", ram_cs_n, 1);
    check("rst_busy", busy, 0);
    check("rst_wr", ram_wr, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_gnt", {dis_gnt, rec_gnt, mc_gnt}, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b0;

    // Write burst: rec 0x0010, 4 beats
    @(negedge clk);
    rec_req = 1; rec_addr = 14'h0010; rec_len = 3;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rec_wdata = 32'hA000_0000 | k;
      #1;
      if (k == 0) rec_req = 0;
      ea = 14'h0010 + 14'(k);
      check("wr_gnt", rec_gnt, (k == 0));
      check("wr_cs_n", ram_cs_n, 0);
      check("wr_wr", ram_wr, 1);
      check("wr_addr", ram_addr, ea);
      check("wr_wready", rec_wready, 1);
      check("wr_wdata", ram_wdata, 32'hA000_0000 | k);
    end
    @(negedge clk);
    check("wr_end_cs_n", ram_cs_n, 1);
    check("wr_end_wready", rec_wready, 0);
    check("wr_end_wdata", ram_wdata, 0);
    check("wr_end_busy", busy, 0);

    // Wrapping mc read at 0x3FFE
    mc_req = 1; mc_addr = 14'h3FFE; mc_len = 3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) mc_req = 0;
      if (i > 0) ram_rdata = 32'hC0DE_0000 | i;
      #1;
      ea = 14'h3FFE + 14'(i);
      if (i < 4) begin
        check("wrap_cs_n", ram_cs_n, 0);
        check("wrap_addr", ram_addr, ea);
        check("wrap_gnt", mc_gnt, (i == 0));
        check("wrap_wr", ram_wr, 0);
      end else begin
        check("wrap_end_cs_n", ram_cs_n, 1);
      end
      check("wrap_mc_rvalid", mc_rvalid, (i > 0));
      check("wrap_dis_rvalid", dis_rvalid, 0);
      if (i > 0) check("wrap_rdata", rdata, 32'hC0DE_0000 | i);
    end
    @(negedge clk);
    check("wrap_rvalid_off", mc_rvalid, 0);

    // Priority: all three at once, single-beat bursts
    dis_req = 1; rec_req = 1; mc_req = 1;
    dis_len = 0; rec_len = 0; mc_len = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      eg = prio_seq[i];
      check("prio_gnt", {dis_gnt, rec_gnt, mc_gnt}, eg);
      check("prio_cs_n", ram_cs_n, (eg == 3'b000));
      check("prio_excl", $onehot0({dis_gnt, rec_gnt, mc_gnt, dis_rvalid, mc_rvalid}), 1);
      if (eg[2]) dis_req = 0;
      if (eg[1]) rec_req = 0;
      if (eg[0]) mc_req = 0;
    end

    // Fairness: rec and mc held continuously
    rec_req = 1; mc_req = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("fair_gnt", {dis_gnt, rec_gnt, mc_gnt}, fair_seq[i]);
      if (i == 6) begin
        rec_req = 0;
        mc_req = 0;
      end
    end

    // Reset during beat 2 of an 8-beat write
    @(negedge clk);
    rec_req = 1; rec_addr = 14'h0100; rec_len = 7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (k == 0) rec_req = 0;
      check("rst_mid_addr", ram_addr, 14'h0100 + 14'(k));
    end
    reset = 1;
    #1;
    check("rst_mid_cs_n", ram_cs_n, 1);
    check("rst_mid_wr", ram_wr, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_wready", rec_wready, 0);
    @(negedge clk);
    reset = 0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!ram_cs_n || dis_rvalid || mc_rvalid) stray++;
    end
    check("rst_mid_no_beats", stray, 0);

    // Display burst of 16 with inputs changed mid-burst
    dis_req = 1; dis_addr = 14'h0200; dis_len = 15;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      if (k == 0) begin
        dis_req = 0;
        dis_addr = 14'h3000;
        dis_len = 0;
      end
      check("dis16_addr", ram_addr, 14'h0200 + 14'(k));
      check("dis16_cs_n", ram_cs_n, 0);
      check("dis16_gnt", dis_gnt, (k == 0));
    end
    @(negedge clk);
    check("dis16_end_cs_n", ram_cs_n, 1);
    check("dis16_last_rvalid", dis_rvalid, 1);
    @(negedge clk);
    check("dis16_idle", ram_cs_n, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
